// File: rtl/sq_sum_col_seq.sv
// sq_sum_col_seq: issues one grid column per cycle to a shared adder tree and gathers the column sums.
// Define SQ_SUM_COL_SEQ_PERF_EN to add the perf_grids_o output-handshake counter.
module sq_sum_col_seq #(
    parameter int NumCols     = 8,
    parameter int TreeLatency = 0,
    parameter int Rows        = 8,
    parameter int TermBits    = 8,
    parameter int SumBits     = 11
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    input  logic [Rows-1:0][NumCols-1:0][TermBits-1:0] grid_i,
    output logic [Rows-1:0][TermBits-1:0]              tree_terms_o,
    input  logic [SumBits-1:0]                         tree_sum_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [NumCols-1:0][SumBits-1:0]            sums_o,
`ifdef SQ_SUM_COL_SEQ_PERF_EN
    output logic [31:0]                                perf_grids_o,
`endif
    output logic                                      busy_o
);
    localparam int ColBits = (NumCols > 1) ? $clog2(NumCols) : 1;
    localparam logic [ColBits-1:0] LastCol = ColBits'(NumCols - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                                    state_q, state_d;
    logic [ColBits-1:0]                        col_q;
    logic [Rows-1:0][NumCols-1:0][TermBits-1:0] grid_q;
    logic [NumCols-1:0][SumBits-1:0]           sums_q;
    logic                                      issue;
    logic                                      drain_last;

    assign sums_o = sums_q;

    always_comb begin
        state_d      = state_q;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = 1'b1;
        tree_terms_o = '0;
        issue        = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) state_d = ISSUE;
            end
            ISSUE: begin
                issue = 1'b1;
                for (int r = 0; r < Rows; r++) tree_terms_o[r] = grid_q[r][col_q];
                if (col_q == LastCol) state_d = (TreeLatency == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (drain_last) state_d = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            col_q   <= '0;
            grid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (in_ready_o && in_valid_i) grid_q <= grid_i;
            if (issue) col_q <= (col_q == LastCol) ? '0 : col_q + 1'b1;
        end
    end

    generate
        if (TreeLatency == 0) begin : g_comb_tree
            assign drain_last = 1'b1;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sums_q <= '0;
                else if (issue) sums_q[col_q] <= tree_sum_i;
            end
        end else begin : g_pipe_tree
            localparam int CntBits = (TreeLatency > 1) ? $clog2(TreeLatency) : 1;
            localparam logic [CntBits-1:0] LastCnt = CntBits'(TreeLatency - 1);

            logic [CntBits-1:0]                  drain_cnt;
            logic [TreeLatency-1:0]              tag_valid;
            logic [TreeLatency-1:0][ColBits-1:0] tag_idx;

            assign drain_last = (drain_cnt == LastCnt);

            // Each issued column carries its index down the tag pipe so the sum lands in the right slot.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    drain_cnt <= '0;
                    tag_valid <= '0;
                    tag_idx   <= '0;
                    sums_q    <= '0;
                end else begin
                    drain_cnt    <= (state_q == DRAIN) ? drain_cnt + 1'b1 : '0;
                    tag_valid[0] <= issue;
                    tag_idx[0]   <= col_q;
                    for (int i = 1; i < TreeLatency; i++) begin
                        tag_valid[i] <= tag_valid[i-1];
                        tag_idx[i]   <= tag_idx[i-1];
                    end
                    if (tag_valid[TreeLatency-1]) sums_q[tag_idx[TreeLatency-1]] <= tree_sum_i;
                end
            end
        end
    endgenerate

`ifdef SQ_SUM_COL_SEQ_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_grids_o <= '0;
        else if (out_valid_o && out_ready_i && (perf_grids_o != 32'hFFFF_FFFF))
            perf_grids_o <= perf_grids_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sq_sum_col_seq.sv
// tb_sq_sum_col_seq: drives a combinational-tree instance and a 2-cycle flopped-tree instance
// of sq_sum_col_seq, with a scoreboard of expected column sums per instance.
module tb_sq_sum_col_seq;
    localparam int N  = 4;
    localparam int R  = 5;
    localparam int TW = 6;
    localparam int SW = 9;

    typedef logic [R-1:0][N-1:0][TW-1:0] grid_t;
    typedef logic [N-1:0][SW-1:0]        sums_t;
    typedef logic [R-1:0][TW-1:0]        terms_t;

    typedef struct {
        grid_t g;
        sums_t exp;
        int    hold;
        bit    early;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid[2];
    logic        out_ready[2];
    grid_t       grid[2];
    logic        in_ready[2];
    logic        out_valid[2];
    logic        busy[2];
    terms_t      terms[2];
    logic [SW-1:0] tsum[2];
    sums_t       sums[2];
    logic [31:0] perf[2];

    int    tests_run  = 0;
    int    fail_count = 0;
    sums_t q0[$];
    sums_t q1[$];
    vec_t  vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sq_sum_col_seq #(.NumCols(N), .TreeLatency(0), .Rows(R), .TermBits(TW), .SumBits(SW)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .grid_i(grid[0]), .tree_terms_o(terms[0]), .tree_sum_i(tsum[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .sums_o(sums[0]),
`ifdef SQ_SUM_COL_SEQ_PERF_EN
        .perf_grids_o(perf[0]),
`endif
        .busy_o(busy[0])
    );

    sq_sum_col_seq #(.NumCols(N), .TreeLatency(2), .Rows(R), .TermBits(TW), .SumBits(SW)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .grid_i(grid[1]), .tree_terms_o(terms[1]), .tree_sum_i(tsum[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .sums_o(sums[1]),
`ifdef SQ_SUM_COL_SEQ_PERF_EN
        .perf_grids_o(perf[1]),
`endif
        .busy_o(busy[1])
    );

`ifndef SQ_SUM_COL_SEQ_PERF_EN
    assign perf[0] = '0;
    assign perf[1] = '0;
`endif

    function automatic logic [SW-1:0] tree_add(input terms_t t);
        logic [SW-1:0] s;
        s = '0;
        for (int r = 0; r < R; r++) s = s + SW'(t[r]);
        return s;
    endfunction

    function automatic sums_t col_sums(input grid_t g);
        sums_t s;
        s = '0;
        for (int c = 0; c < N; c++)
            for (int r = 0; r < R; r++) s[c] = s[c] + SW'(g[r][c]);
        return s;
    endfunction

    function automatic terms_t col_of(input grid_t g, input int c);
        terms_t t;
        for (int r = 0; r < R; r++) t[r] = g[r][c];
        return t;
    endfunction

    // Tree models: combinational for instance 0, input and output flopped for instance 1.
    terms_t        tree_in;
    logic [SW-1:0] tree_out;
    assign tsum[0] = tree_add(terms[0]);
    always_ff @(posedge clk) begin
        tree_in  <= terms[1];
        tree_out <= tree_add(tree_in);
    end
    assign tsum[1] = tree_out;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int u);
        sums_t exp;
        if (out_valid[u] && out_ready[u]) begin
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                tests_run++;
                fail_count++;
                $display("[TB] FAIL sb_unexpected_u%0d: output handshake with no pending grid, got 0x%0h", u, sums[u]);
            end else begin
                exp = (u == 0) ? q0.pop_front() : q1.pop_front();
                checkOutput($sformatf("sb_sums_u%0d", u), sums[u], exp);
            end
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            sb_pop(0);
            sb_pop(1);
        end
    end

    task automatic sb_push(input int u, input sums_t s);
        if (u == 0) q0.push_back(s);
        else q1.push_back(s);
    endtask

    task automatic check_reset_state(input int u, input string tag);
        checkOutput($sformatf("%s_ctl_u%0d", tag, u), {in_ready[u], out_valid[u], busy[u]}, 3'b100);
        checkOutput($sformatf("%s_terms_u%0d", tag, u), terms[u], '0);
        checkOutput($sformatf("%s_sums_u%0d", tag, u), sums[u], '0);
`ifdef SQ_SUM_COL_SEQ_PERF_EN
        checkOutput($sformatf("%s_perf_u%0d", tag, u), perf[u], 32'd0);
`endif
    endtask

    task automatic wait_accept(input int u, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[u]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput($sformatf("accept_timeout_u%0d", u), 0, 1);
    endtask

    task automatic applyStimulus(input int u, input vec_t v);
        int    lat;
        bit    ok, ir_low, terms_ok, drain_zero, stable;
        sums_t held;
        @(posedge clk); #1;
        grid[u]      = v.g;
        in_valid[u]  = 1'b1;
        out_ready[u] = v.early;
        wait_accept(u, ok);
        sb_push(u, v.exp);
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        grid[u]     = '1;
        lat = -1; ir_low = 1; terms_ok = 1; drain_zero = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid[u]) begin
                lat = k;
                break;
            end
            if (in_ready[u] || !busy[u]) ir_low = 0;
            if (k < N) begin
                if (terms[u] !== col_of(v.g, k)) terms_ok = 0;
            end else if (terms[u] !== '0) drain_zero = 0;
        end
        checkOutput($sformatf("latency_u%0d", u), lat, N + 2 * u);
        checkOutput($sformatf("in_ready_low_u%0d", u), ir_low, 1);
        checkOutput($sformatf("issue_terms_u%0d", u), terms_ok, 1);
        if (u == 1) checkOutput("drain_terms_zero_u1", drain_zero, 1);
        if (!v.early) begin
            held = sums[u];
            stable = 1;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!out_valid[u] || sums[u] !== held || in_ready[u] || !busy[u] || terms[u] !== '0)
                    stable = 0;
            end
            if (v.hold > 0) checkOutput($sformatf("done_hold_u%0d", u), stable, 1);
            @(posedge clk); #1;
            out_ready[u] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("idle_after_hs_u%0d", u), {in_ready[u], out_valid[u], busy[u]}, 3'b100);
    endtask

    task automatic reset_mid_issue(input int u);
        bit ok;
        @(posedge clk); #1;
        grid[u]     = vecs[3].g;
        in_valid[u] = 1'b1;
        wait_accept(u, ok);
        sb_push(u, vecs[3].exp);
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput($sformatf("pre_reset_col2_u%0d", u), terms[u], col_of(vecs[3].g, 2));
        rst = 1'b1;
        if (u == 0) q0.delete();
        else q1.delete();
        #1;
        check_reset_state(u, "mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state(u, "post_reset");
    endtask

    task automatic back_to_back(input int u);
        int acc, hs, last_hs;
        bit gap_ok, acc_now, hs_now;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc = 0; hs = 0; last_hs = -10; gap_ok = 1;
        grid[u]      = vecs[0].g;
        in_valid[u]  = 1'b1;
        out_ready[u] = 1'b1;
        for (int cyc = 0; cyc < 200 && hs < 3; cyc++) begin
            @(negedge clk);
            acc_now = in_valid[u] && in_ready[u];
            hs_now  = out_valid[u] && out_ready[u];
            if (acc_now) begin
                sb_push(u, vecs[acc].exp);
                if (acc > 0 && cyc != last_hs + 1) gap_ok = 0;
                acc++;
            end
            if (hs_now) begin
                last_hs = cyc;
                hs++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                if (acc < 3) grid[u] = vecs[acc].g;
                else in_valid[u] = 1'b0;
            end
        end
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b0;
        checkOutput($sformatf("b2b_accepts_u%0d", u), acc, 3);
        checkOutput($sformatf("b2b_handshakes_u%0d", u), hs, 3);
        checkOutput($sformatf("b2b_accept_gap_u%0d", u), gap_ok, 1);
`ifdef SQ_SUM_COL_SEQ_PERF_EN
        @(negedge clk);
        checkOutput($sformatf("perf_grids_u%0d", u), perf[u], 32'd3);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < R; r++) begin
                vecs[0].g[r][c] = TW'(c + 1);
                vecs[2].g[r][c] = TW'($urandom_range(0, (1 << TW) - 1));
                vecs[3].g[r][c] = TW'(r * 11 + c * 3);
            end
            vecs[0].exp[c] = SW'(R * (c + 1));
            vecs[1].exp[c] = SW'(R * ((1 << TW) - 1));
        end
        vecs[1].g   = '1;
        vecs[2].exp = col_sums(vecs[2].g);
        vecs[3].exp = col_sums(vecs[3].g);
        vecs[0].hold = 0;  vecs[0].early = 1'b1;
        vecs[1].hold = 10; vecs[1].early = 1'b0;
        vecs[2].hold = 3;  vecs[2].early = 1'b0;
        vecs[3].hold = 0;  vecs[3].early = 1'b0;

        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b0;
            grid[u]      = '0;
        end
        repeat (2) @(negedge clk);
        check_reset_state(0, "in_reset");
        check_reset_state(1, "in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state(0, "after_reset");
        check_reset_state(1, "after_reset");

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 4; i++) applyStimulus(u, vecs[i]);

        for (int u = 0; u < 2; u++) begin
            reset_mid_issue(u);
            applyStimulus(u, vecs[0]);
        end

        back_to_back(0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", {32'(q0.size()), 32'(q1.size())}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
